// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters (fetch F, data D), the arbiter and external memory.
// slave: the arbiter's view; master: the requester/memory side.
interface memory_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fetch_request;
  logic [DATA_WIDTH-1:0] fetch_address;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_read_data;

  logic                  data_request;
  logic [DATA_WIDTH-1:0] data_address;
  logic                  data_write_enable;
  logic [DATA_WIDTH-1:0] data_write_data;
  logic                  data_ready;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] data_read_data;

  logic [DATA_WIDTH-1:0] memory_address;
  logic                  memory_write_enable;
  logic [DATA_WIDTH-1:0] memory_write_data;
  logic [DATA_WIDTH-1:0] memory_read_data;

  modport slave (
    input  fetch_request, fetch_address,
    input  data_request, data_address, data_write_enable, data_write_data,
    input  memory_read_data,
    output fetch_ready, fetch_valid, fetch_read_data,
    output data_ready, data_valid, data_read_data,
    output memory_address, memory_write_enable, memory_write_data
  );

  modport master (
    output fetch_request, fetch_address,
    output data_request, data_address, data_write_enable, data_write_data,
    output memory_read_data,
    input  fetch_ready, fetch_valid, fetch_read_data,
    input  data_ready, data_valid, data_read_data,
    input  memory_address, memory_write_enable, memory_write_data
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch / data) arbiter onto a single fixed-latency memory bus.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; default is data-over-fetch priority.
module memory_arbiter #(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input logic             clock,
  input logic             reset,
  memory_arbiter_if.slave bus
);

  localparam int unsigned COUNT_WIDTH = 4;
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;
  typedef enum logic {PORT_F, PORT_D} port_t;

  state_t                 state, state_next;
  logic [COUNT_WIDTH-1:0] count, count_next;
  port_t                  grant, grant_next;
  port_t                  last_grant, last_grant_next;
  logic [DATA_WIDTH-1:0]  address_q, address_next;
  logic                   write_enable_q, write_enable_next;
  logic [DATA_WIDTH-1:0]  write_data_q, write_data_next;
  logic [DATA_WIDTH-1:0]  read_data_q, read_data_next;
  port_t                  winner;

  // State and captured-request registers; reset abandons any in-flight access.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      grant          <= PORT_F;
      last_grant     <= PORT_D;
      address_q      <= '0;
      write_enable_q <= 1'b0;
      write_data_q   <= '0;
      read_data_q    <= '0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      grant          <= grant_next;
      last_grant     <= last_grant_next;
      address_q      <= address_next;
      write_enable_q <= write_enable_next;
      write_data_q   <= write_data_next;
      read_data_q    <= read_data_next;
    end
  end

  // Next-state, accept decision and bus outputs; everything is held at 0 while reset is low.
  always_comb begin
    state_next          = state;
    count_next          = count;
    grant_next          = grant;
    last_grant_next     = last_grant;
    address_next        = address_q;
    write_enable_next   = write_enable_q;
    write_data_next     = write_data_q;
    read_data_next      = read_data_q;
    winner              = PORT_F;

    bus.fetch_ready         = 1'b0;
    bus.fetch_valid         = 1'b0;
    bus.fetch_read_data     = '0;
    bus.data_ready          = 1'b0;
    bus.data_valid          = 1'b0;
    bus.data_read_data      = '0;
    bus.memory_address      = '0;
    bus.memory_write_enable = 1'b0;
    bus.memory_write_data   = '0;

    if (reset) begin
      case (state)
        BUSY: begin
          bus.memory_address      = address_q;
          bus.memory_write_data   = write_data_q;
          // A store is written only in the first memory cycle.
          bus.memory_write_enable = write_enable_q && (count == '0);
          count_next              = count + COUNT_WIDTH'(1);
          if (count == LAST_COUNT) begin
            read_data_next = write_enable_q ? '0 : bus.memory_read_data;
            state_next     = RESPOND;
          end
        end
        RESPOND: begin
          if (grant == PORT_D) begin
            bus.data_valid     = 1'b1;
            bus.data_read_data = read_data_q;
          end else begin
            bus.fetch_valid     = 1'b1;
            bus.fetch_read_data = read_data_q;
          end
          state_next = IDLE;
        end
        default: ;
      endcase

      // Accept in IDLE or RESPOND; a RESPOND-cycle accept gives back-to-back throughput.
      if ((state != BUSY) && (bus.fetch_request || bus.data_request)) begin
        if (bus.data_request && !bus.fetch_request) begin
          winner = PORT_D;
        end else if (bus.fetch_request && !bus.data_request) begin
          winner = PORT_F;
        end else begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          winner = (last_grant == PORT_D) ? PORT_F : PORT_D;
`else
          winner = PORT_D;
`endif
        end

        state_next      = BUSY;
        count_next      = '0;
        grant_next      = winner;
        last_grant_next = winner;
        if (winner == PORT_D) begin
          bus.data_ready    = 1'b1;
          address_next      = bus.data_address;
          write_enable_next = bus.data_write_enable;
          write_data_next   = bus.data_write_data;
        end else begin
          bus.fetch_ready   = 1'b1;
          address_next      = bus.fetch_address;
          write_enable_next = 1'b0;
          write_data_next   = '0;
        end
      end
    end
  end

endmodule
